// File: rtl/ej32_pkg.sv
// Shared definitions for the eJ32 data-stack slice: stack op encoding and default sizes.
package ej32_pkg;

  typedef enum logic [1:0] {
    sNOP  = 2'd0,
    sPUSH = 2'd1,
    sPOP  = 2'd2,
    sMOVE = 2'd3
  } stack_op_t;

  localparam int SS_DEPTH = 64;
  localparam int SS_DSZ   = 32;

endpackage

// File: rtl/ej32_ss_ram.sv
// Spill RAM below the NOS register: one synchronous write port, one combinational read port.
module ej32_ss_ram #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int ASZ   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [ASZ-1:0] waddr,
  input  logic [DSZ-1:0] wdata,
  input  logic [ASZ-1:0] raddr,
  output logic [DSZ-1:0] rdata
);

  // NOS lives in a register, so only DEPTH-1 entries are needed here.
  logic [DSZ-1:0] mem [0:DEPTH-2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ej32_sstack.sv
// eJ32 data stack (slave side of ss_io): NOS register `s`, spill RAM, depth counter and sticky flags.
// Optional high-water-mark output `hwm` is built when EJ32_SSTACK_HWM_EN is defined.
module ej32_sstack
  import ej32_pkg::*;
#(
  parameter int DEPTH = SS_DEPTH,
  parameter int DSZ   = SS_DSZ,
  parameter int ASZ   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] s,
  output logic [ASZ:0]   cnt,
  output logic           full,
  output logic           empty,
  output logic           ovf,
  output logic           unf
`ifdef EJ32_SSTACK_HWM_EN
  , output logic [ASZ:0] hwm
`endif
);

  localparam logic [ASZ:0] CNT_MAX = (ASZ+1)'(DEPTH);
  localparam logic [ASZ:0] ONE     = (ASZ+1)'(1);
  localparam logic [ASZ:0] TWO     = (ASZ+1)'(2);

  stack_op_t      op_e;
  logic [ASZ:0]   cnt_m1;
  logic [ASZ:0]   cnt_m2;
  logic           ram_we;
  logic [DSZ-1:0] ram_rdata;

  assign op_e   = stack_op_t'(op);
  assign full   = (cnt == CNT_MAX);
  assign empty  = (cnt == '0);
  assign cnt_m1 = cnt - ONE;
  assign cnt_m2 = cnt - TWO;

  // Old NOS spills at cnt-1 while a pop refills from cnt-2, so the ports never collide.
  assign ram_we = (op_e == sPUSH) && !full && !empty;

  ej32_ss_ram #(
    .DEPTH (DEPTH),
    .DSZ   (DSZ),
    .ASZ   (ASZ)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cnt_m1[ASZ-1:0]),
    .wdata (s),
    .raddr (cnt_m2[ASZ-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      s   <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      case (op_e)
        sNOP: ;
        sPUSH: begin
          if (!full) begin
            s   <= vi;
            cnt <= cnt + ONE;
          end else begin
            ovf <= 1'b1;
          end
        end
        sPOP: begin
          if (cnt >= TWO) begin
            s   <= ram_rdata;
            cnt <= cnt_m1;
          end else if (cnt == ONE) begin
            s   <= '0;
            cnt <= '0;
          end else begin
            unf <= 1'b1;
          end
        end
        sMOVE: begin
          // A store over an empty stack becomes the first entry.
          s <= vi;
          if (empty) cnt <= ONE;
        end
      endcase
    end
  end

`ifdef EJ32_SSTACK_HWM_EN
  logic push_acc;
  assign push_acc = ((op_e == sPUSH) && !full) || ((op_e == sMOVE) && empty);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hwm <= '0;
    end else if (push_acc && ((cnt + ONE) > hwm)) begin
      hwm <= cnt + ONE;
    end
  end
`endif

endmodule
